// File: rtl/poly_operand_sequencer.sv
// poly_operand_sequencer: replays a captured {A,B,C,X} set into the quadratic evaluator's go/data_in protocol and returns its result
module poly_operand_sequencer #(
  parameter int DATA_W         = 8,
  parameter int GO_HIGH        = 2,
  parameter int GO_LOW         = 2,
  parameter int COMPUTE_CYCLES = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_c,
  input  logic [DATA_W-1:0] in_x,
  output logic [DATA_W-1:0] eval_data_in,
  output logic              eval_go,
  input  logic [DATA_W-1:0] eval_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              busy
);
  localparam int TMAX = (GO_HIGH > GO_LOW) ? ((GO_HIGH > COMPUTE_CYCLES) ? GO_HIGH : COMPUTE_CYCLES)
                                           : ((GO_LOW > COMPUTE_CYCLES) ? GO_LOW : COMPUTE_CYCLES);
  localparam int TW = $clog2(TMAX + 1);
  typedef enum logic [2:0] {IDLE, DRIVE, RELEASE, COMPUTE, HOLD} state_t;
  state_t            state_q;
  logic [1:0]        idx_q;
  logic [TW-1:0]     tmr_q;
  logic [DATA_W-1:0] a_q, b_q, c_q, x_q, din_q, res_q, op_d;
  logic              go_q;
  // operand loaded alongside the next go rise, so data_in never moves while go is high
  always_comb op_d = (idx_q == 2'd0) ? b_q : (idx_q == 2'd1) ? c_q : x_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tmr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      x_q     <= '0;
      din_q   <= '0;
      res_q   <= '0;
      go_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= in_a;
          b_q     <= in_b;
          c_q     <= in_c;
          x_q     <= in_x;
          din_q   <= in_a;
          go_q    <= 1'b1;
          idx_q   <= '0;
          tmr_q   <= '0;
          state_q <= DRIVE;
        end
        DRIVE: if (tmr_q == TW'(GO_HIGH - 1)) begin
          go_q    <= 1'b0;
          tmr_q   <= '0;
          state_q <= RELEASE;
        end else tmr_q <= tmr_q + TW'(1);
        RELEASE: if (tmr_q == TW'(GO_LOW - 1)) begin
          tmr_q <= '0;
          if (idx_q == 2'd3) state_q <= COMPUTE;
          else begin
            idx_q   <= idx_q + 2'd1;
            din_q   <= op_d;
            go_q    <= 1'b1;
            state_q <= DRIVE;
          end
        end else tmr_q <= tmr_q + TW'(1);
        COMPUTE: if (tmr_q == TW'(COMPUTE_CYCLES - 1)) begin
          res_q   <= eval_result;
          tmr_q   <= '0;
          state_q <= HOLD;
        end else tmr_q <= tmr_q + TW'(1);
        HOLD: if (res_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready     = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign res_valid    = (state_q == HOLD);
  assign res_data     = res_q;
  assign eval_go      = go_q;
  assign eval_data_in = din_q;
endmodule

// File: tb/tb_poly_operand_sequencer.sv
// tb_poly_operand_sequencer: random and directed operand sets against a scoreboard and a behavioural evaluator model
module tb_poly_operand_sequencer;
  localparam int GH = 2, GL = 2, CC = 8, LAT = 4 * (GH + GL) + CC;
  logic       clk = 0, resetn = 0, in_valid = 0, res_ready = 0;
  logic [7:0] in_a = 0, in_b = 0, in_c = 0, in_x = 0, eval_result = 0;
  logic [7:0] eval_data_in, res_data;
  logic       in_ready, eval_go, res_valid, busy;
  int vecs = 0, errs = 0, cyc = 0;
  logic [7:0] sbq[$];
  logic [7:0] cur_ops[4];
  logic [7:0] seen[4];
  logic [7:0] model_res = 0, last_din = 0;
  bit   tb_busy = 0, go_prev = 0, rnd_rr = 0;
  int   acc_cyc = 0, expect_acc = 0, op_n = 0, rise_cyc = 0, res_cd = 0;

  poly_operand_sequencer #(.DATA_W(8), .GO_HIGH(GH), .GO_LOW(GL), .COMPUTE_CYCLES(CC)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_x(in_x),
    .eval_data_in(eval_data_in), .eval_go(eval_go), .eval_result(eval_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] quad(input logic [7:0] a, b, c, x);
    int t;
    t = int'(a) * int'(x) * int'(x) + int'(b) * int'(x) + int'(c);
    return t[7:0];
  endfunction

  // monitor, scoreboard and evaluator model, all sampled mid-cycle
  always @(negedge clk) begin
    if (!resetn) begin
      sbq.delete();
      tb_busy = 0; expect_acc = 0; op_n = 0; go_prev = 0; res_cd = 0; eval_result = 0;
    end else begin
      if (res_cd > 1) begin res_cd--; eval_result = 8'($urandom); end
      else if (res_cd == 1) begin res_cd = 0; eval_result = model_res; end
      chk("busy", busy, tb_busy);
      chk("in_ready", in_ready, !tb_busy);
      chk("res_valid", res_valid, tb_busy && (cyc - acc_cyc >= LAT));
      if (!tb_busy) chk("go_idle", eval_go, 0);
      if (res_valid && sbq.size() > 0) chk("res_data", res_data, sbq[0]);
      if (eval_go && go_prev) chk("data_stable", eval_data_in, last_din);
      if (eval_go && !go_prev) begin
        chk("go_rise_count", op_n < 4, 1);
        if (op_n < 4) begin
          chk("go_rise_cycle", cyc - acc_cyc, op_n * (GH + GL));
          chk("data_in", eval_data_in, cur_ops[op_n]);
          seen[op_n] = eval_data_in;
          if (op_n == 0) eval_result = 8'($urandom);
          op_n++;
        end
        rise_cyc = cyc;
      end
      if (!eval_go && go_prev) begin
        chk("go_high_len", cyc - rise_cyc, GH);
        if (op_n == 4) begin
          model_res = quad(seen[0], seen[1], seen[2], seen[3]);
          res_cd = 5;
        end
      end
      if (tb_busy) begin
        if (res_valid && res_ready) begin
          chk("go_count", op_n, 4);
          if (sbq.size() > 0) void'(sbq.pop_front());
          tb_busy = 0;
          if (in_valid) expect_acc = cyc + 2;
        end
      end else if (in_valid) begin
        acc_cyc = cyc + 1;
        sbq.push_back(quad(in_a, in_b, in_c, in_x));
        cur_ops = '{in_a, in_b, in_c, in_x};
        op_n = 0;
        tb_busy = 1;
        if (expect_acc != 0) chk("b2b_accept_cycle", acc_cyc, expect_acc);
        expect_acc = 0;
      end
      go_prev = eval_go;
      last_din = eval_data_in;
    end
  end

  task automatic present(input logic [7:0] a, b, c, x);
    @(posedge clk); #1;
    in_a = a; in_b = b; in_c = c; in_x = x; in_valid = 1;
  endtask

  task automatic wait_acc();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0;
    in_a = 8'($urandom); in_b = 8'($urandom); in_c = 8'($urandom); in_x = 8'($urandom);
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk); #1;
      if (rnd_rr) res_ready = $urandom_range(0, 1);
      if (!tb_busy) ok = 1;
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_eval_go", eval_go, 0);
    chk("rst_eval_data_in", eval_data_in, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_busy", busy, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_vals();
    @(posedge clk); #1 resetn = 1;
    res_ready = 1;
    present(2, 3, 4, 5); wait_acc(); wait_done();
    chk("t_2_3_4_5", res_data, 8'h45);
    present(10, 0, 0, 10); wait_acc(); wait_done();
    chk("t_10_0_0_10", res_data, 8'hE8);
    present(8'hFF, 1, 1, 1); wait_acc(); wait_done();
    chk("t_ff_1_1_1", res_data, 8'h01);
    // backpressure: result held ten cycles while a second set waits
    res_ready = 0;
    present(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)); wait_acc();
    for (int i = 0; i < 100 && !res_valid; i++) @(posedge clk);
    present(3, 7, 9, 11);
    repeat (10) @(posedge clk);
    #1 res_ready = 1;
    wait_acc(); wait_done();
    chk("t_backpressure_2nd", res_data, quad(3, 7, 9, 11));
    // back-to-back with continuous valid and ready
    present(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)); wait_acc();
    present(4, 5, 6, 7); wait_acc(); wait_done();
    chk("t_b2b_2nd", res_data, quad(4, 5, 6, 7));
    // reset while in RELEASE of C
    present(9, 9, 9, 9); wait_acc();
    repeat (10) @(posedge clk);
    #1 resetn = 0;
    #1 chk_reset_vals();
    @(posedge clk); #1 resetn = 1;
    present(1, 1, 1, 2); wait_acc(); wait_done();
    chk("t_after_reset", res_data, 8'h07);
    rnd_rr = 1;
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      present(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      wait_acc(); wait_done();
    end
    rnd_rr = 0;
    res_ready = 1;
    repeat (3) @(posedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errs=%0d", errs);
    $fatal(1);
  end
endmodule
